// File: rtl/bin2bcd_pkg.sv
// ============================================================================
// Module   : bin2bcd_pkg
// Brief    : Shared constants, state encoding and sizing helper for bin2bcd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin2bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        CONV = ST_CONV
    } state_e;

    // ceil(bin_w * log10(2)) in integer arithmetic (log10 2 ~= 0.30103)
    function automatic int min_bcd_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add3.sv
// ============================================================================
// Module   : bcd_digit_add3
// Brief    : Combinational double-dabble cell: digit >= 5 gets +3 (mod 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_add3
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq_ctrl.sv
// ============================================================================
// Module   : bin2bcd_seq_ctrl
// Brief    : Sequential binary-to-BCD converter, one bit per clock, with
//            start/busy/done handshake. Optional leading-zero mask output
//            enabled by macro BIN2BCD_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W      = 16,
    parameter int BCD_DIGITS = 5
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*BCD_DIGITS-1:0] bcd_out
`ifdef BIN2BCD_LZ_BLANK_EN
    ,
    output logic [BCD_DIGITS-1:0]         lz_mask
`endif
);

    localparam int BCD_W = DIGIT_W * BCD_DIGITS;
    localparam int SR_W  = BIN_W + BCD_W;
    localparam int CNT_W = $clog2(BIN_W);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sr;
    logic [BCD_W-1:0] w_corr;
    logic [SR_W-1:0]  w_next_sr;
    logic [BCD_W-1:0] w_bcd_next;

    // Correction happens on the current BCD field, then the whole register shifts.
    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
            bcd_digit_add3 u_add3 (
                .i_digit (r_sr[BIN_W + g*DIGIT_W +: DIGIT_W]),
                .o_digit (w_corr[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign w_next_sr  = {w_corr, r_sr[BIN_W-1:0]} << 1;
    assign w_bcd_next = w_next_sr[SR_W-1:BIN_W];

`ifdef BIN2BCD_LZ_BLANK_EN
    logic [BCD_DIGITS-1:0] w_lz;
    logic                  w_zero_above;

    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (w_bcd_next[i*DIGIT_W +: DIGIT_W] == 4'd0);
            w_lz[i]      = w_zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lz_mask <= {{(BCD_DIGITS-1){1'b1}}, 1'b0};
        end else if (r_state == ST_CONV && r_cnt == '0) begin
            lz_mask <= w_lz;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sr    <= {{BCD_W{1'b0}}, bin_in};
                        r_cnt   <= CNT_W'(BIN_W - 1);
                        busy    <= 1'b1;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_sr  <= w_next_sr;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        bcd_out <= w_bcd_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq_ctrl.sv
// ============================================================================
// Module   : tb_bin2bcd_seq_ctrl
// Brief    : Directed self-checking bench for bin2bcd_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
`ifdef BIN2BCD_LZ_BLANK_EN
    logic [4:0]  lz_mask;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_seq_ctrl #(.BIN_W(16), .BCD_DIGITS(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BIN2BCD_LZ_BLANK_EN
        ,
        .lz_mask (lz_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lz(input string tag, input logic [4:0] exp);
`ifdef BIN2BCD_LZ_BLANK_EN
        check(tag, {27'd0, lz_mask}, {27'd0, exp});
`else
        if (exp === 5'bx) $display("lz unused");
`endif
    endtask

    // Starts one conversion and returns sampled in the done cycle.
    // glitch_at > 0 drives start=1 with bin_in=999 on that busy cycle.
    task automatic run_conv(input string tag, input logic [15:0] val,
                            input logic [19:0] exp_bcd, input logic [4:0] exp_lz,
                            input int glitch_at);
        int n;
        int busy_cnt;
        start  = 1'b1;
        bin_in = val;
        step();
        start  = 1'b0;
        bin_in = 16'hA5A5;
        check({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
        busy_cnt = busy ? 1 : 0;
        n = 0;
        while (n < 40 && !done) begin
            if (n + 1 == glitch_at) begin
                start  = 1'b1;
                bin_in = 16'd999;
            end
            step();
            start = 1'b0;
            n++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, n, 16);
        check({tag, "_busy_cycles"}, busy_cnt, 16);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_bcd"}, {12'd0, bcd_out}, {12'd0, exp_bcd});
        check_lz({tag, "_lz"}, exp_lz);
    endtask

    initial begin
        int cnt;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 16'd0;
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {12'd0, bcd_out}, 32'h0);
        check_lz("rst_lz", 5'b11110);
        rst_n = 1'b1;
        step();

        run_conv("zero", 16'd0, 20'h00000, 5'b11110, 0);
        step();
        check("zero_done_pulse", {31'd0, done}, 32'd0);

        run_conv("max", 16'd65535, 20'h65535, 5'b00000, 0);
        step();
        check("max_done_pulse", {31'd0, done}, 32'd0);
        check("max_bcd_held", {12'd0, bcd_out}, 32'h65535);

        run_conv("ign", 16'd1234, 20'h01234, 5'b10000, 5);
        cnt = 0;
        repeat (20) begin
            step();
            if (busy || done) cnt++;
        end
        check("ign_no_second", cnt, 0);

        run_conv("b2b_a", 16'd42, 20'h00042, 5'b11100, 0);
        run_conv("b2b_b", 16'd9, 20'h00009, 5'b11110, 0);

        start  = 1'b1;
        bin_in = 16'd500;
        step();
        start  = 1'b0;
        repeat (6) step();
        check("abort_busy_mid", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {12'd0, bcd_out}, 32'h0);
        check_lz("abort_lz", 5'b11110);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            step();
            if (busy || done) cnt++;
        end
        check("abort_no_done", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
